ram_port_arbiter: RTL and testbench

- Shares one single_port_ram instance (32-bit data, 1-cycle registered read) between NUM_REQ requesters (CBG datapath units) using round-robin arbitration.
- Sequences the RAM's synchronous clear after system reset.
- Routes each read response back to the requester that issued it.
- Sits between the CBG requesters and the RAM's ena/wea/addr/din/dout/read_valid pins.

---
 rtl/ram_port_arbiter_pkg.sv | 22 ++
 rtl/ram_port_arbiter_rr_picker.sv | 35 +++
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter.
// `A_W sets the RAM address width (word address is `A_W-1 bits wide).
`ifndef A_W
`define A_W 9
`endif

package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = `A_W - 1;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    INIT_SYNC = 2'd0,
    CLEAR     = 2'd1,
    RUN       = 2'd2
  } arb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first asserted req at or
// above ptr wins, otherwise the lowest asserted req below ptr.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) >= ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
        gnt[i] = 1'b1;
      end
    end
    // Wrapped pass: nothing at or above ptr, take the lowest index.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port RAM between NUM_REQ requesters,
// with post-reset RAM clear sequencing. Optional stats: RAM_ARB_STATS_EN.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [31:0]           rdata,
  output logic                  init_done,
  output logic                  ram_rst,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  input  logic                  ram_read_valid,
  output arb_state_t            fsm_state
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0]         conflict_cnt
`endif
);

  arb_state_t          state, state_nxt;
  logic [1:0]          sync;
  logic                run;
  logic [NUM_REQ-1:0]  req_run;
  logic [ID_W-1:0]     rr_ptr, winner, owner_id;
  logic                found, owner_valid, rd_accept;

  // Reset release synchronizer; state leaves INIT_SYNC once it fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT_SYNC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_SYNC: if (sync[1]) state_nxt = CLEAR;
      CLEAR:     state_nxt = RUN;
      RUN:       state_nxt = RUN;
      default:   state_nxt = INIT_SYNC;
    endcase
  end

  always_comb begin
    run       = (state == RUN);
    init_done = run;
    ram_rst   = !run;
    fsm_state = state;
  end

  assign req_run = run ? req : '0;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req    (req_run),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .winner (winner),
    .found  (found)
  );

  // One-hot grant makes this an AND-OR mux; idle drives zeros.
  always_comb begin
    ram_ena   = found;
    ram_wea   = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    rd_accept = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_wea   = req_we[i];
        ram_addr  = req_addr[i*ADDR_W +: ADDR_W];
        ram_din   = req_wdata[i*32 +: 32];
        rd_accept = !req_we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= '0;
      owner_id    <= '0;
      owner_valid <= 1'b0;
    end else begin
      if (found) rr_ptr <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      owner_valid <= rd_accept;
      if (rd_accept) owner_id <= winner;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      rvalid[i] = ram_read_valid & owner_valid & (owner_id == ID_W'(i));
    rdata = (|rvalid) ? ram_dout : '0;
  end

`ifdef RAM_ARB_STATS_EN
  // Conflicts are counted in every cycle out of reset, not only in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i]) grant_cnt[i*CNT_W +: CNT_W] <= sat_inc(grant_cnt[i*CNT_W +: CNT_W]);
      if ((req & (req - 1'b1)) != '0) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: reference model plus scoreboard,
// with a behavioural single-port RAM attached to the RAM pins.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int AW    = ADDR_W_DEF;
  localparam int IW    = 2;
  localparam int MEM_D = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0, req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*32-1:0]   req_wdata = '0;
  logic [N-1:0]      gnt, rvalid;
  logic [31:0]       rdata, ram_din, ram_dout;
  logic              init_done, ram_rst, ram_ena, ram_wea, ram_read_valid;
  logic [AW-1:0]     ram_addr;
  arb_state_t        fsm_state;
`ifdef RAM_ARB_STATS_EN
  logic [N*CNT_W-1:0] grant_cnt;
  logic [CNT_W-1:0]   conflict_cnt;
  int                 ccnt = 0;
`endif

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .init_done(init_done), .ram_rst(ram_rst), .ram_ena(ram_ena),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_read_valid(ram_read_valid), .fsm_state(fsm_state)
`ifdef RAM_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // clock / reset-independent infrastructure
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM: sync clear, 1-cycle registered read
  logic [31:0] mem [MEM_D];
  always @(posedge clk) begin
    ram_read_valid <= 1'b0;
    if (ram_rst) begin
      for (int i = 0; i < MEM_D; i++) mem[i] <= '0;
      ram_dout <= '0;
    end else if (ram_ena) begin
      if (ram_wea) mem[ram_addr] <= ram_din;
      else begin
        ram_dout       <= mem[ram_addr];
        ram_read_valid <= 1'b1;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  always @(posedge clk) begin
    if (!rst) ccnt = 0;
    else if ($countones(req) > 1) ccnt = ccnt + 1;
  end
`endif

  // reference model and scoreboard
  int              total = 0, bad = 0;
  logic [31:0]     ref_mem [MEM_D];
  int              rr_ref = 0;
  bit              model_run = 0;
  int              gcnt [N];
  logic [IW+31:0]  exp_q [$];
  int              due_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // monitor: rvalid/rdata must match the head of the expected queue when due
  initial begin
    logic [IW+31:0] e;
    forever begin
      @(negedge clk);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("rvalid", rvalid, 64'd1 << e[32 +: IW]);
        check("rdata", rdata, e[31:0]);
      end else begin
        check("rvalid_idle", rvalid, 0);
        check("rdata_idle", rdata, 0);
      end
    end
  end

  // driver: one cycle of stimulus, then check the grant against the model
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                      input logic [N*AW-1:0] a, input logic [N*32-1:0] d);
    int won;
    logic [AW-1:0] ad;
    @(negedge clk); #1;
    req = r; req_we = w; req_addr = a; req_wdata = d;
    #1;
    won = -1;
    if (model_run) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr_ref + k) % N;
        if (won < 0 && r[i]) won = i;
      end
      check("gnt", gnt, (won < 0) ? 64'd0 : (64'd1 << won));
      check("ram_ena", ram_ena, (won >= 0) ? 1 : 0);
      if (won >= 0) begin
        rr_ref = (won + 1) % N;
        gcnt[won]++;
        ad = a[won*AW +: AW];
        check("ram_addr", ram_addr, ad);
        if (w[won]) ref_mem[ad] = d[won*32 +: 32];
        else begin
          exp_q.push_back({IW'(won), ref_mem[ad]});
          due_q.push_back(cyc + 1);
        end
      end
    end else begin
      check("gnt_not_run", gnt, 0);
    end
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    model_run = 0;
    rr_ref = 0;
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < MEM_D; i++) ref_mem[i] = '0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
  endtask

  task automatic release_seq();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_rst", ram_rst, 1);
    check("rst_init_done", init_done, 0);
    check("rst_ram_ena", ram_ena, 0);
    check("rst_ram_bus", {ram_wea, ram_addr, ram_din}, 0);
    rst = 1'b1;
    req = '1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #2;
      check("init_ram_rst", ram_rst, (k < 4) ? 1 : 0);
      check("init_done", init_done, (k >= 4) ? 1 : 0);
      check("init_gnt", gnt, 0);
      if (k == 3) req = '0;
    end
    check("fsm_run", fsm_state, RUN);
    model_run = 1;
  endtask

  function automatic logic [N*AW-1:0] pk_a(input int s, input int v);
    logic [N*AW-1:0] x;
    x = '0;
    x[s*AW +: AW] = AW'(v);
    return x;
  endfunction

  function automatic logic [N*32-1:0] pk_d(input int s, input logic [31:0] v);
    logic [N*32-1:0] x;
    x = '0;
    x[s*32 +: 32] = v;
    return x;
  endfunction

  initial begin
    logic [N*AW-1:0] a;
    logic [N*32-1:0] d;
    assert_reset();
    release_seq();

    // fairness: all four read different addresses, order 0,1,2,3,0,1,2,3
    a = pk_a(0, 1) | pk_a(1, 2) | pk_a(2, 3) | pk_a(3, 4);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0000, a, '0);
      check("fair_order", gnt, 64'd1 << (k % 4));
    end

    // write then read-back on consecutive cycles
    step(4'b0001, 4'b0001, pk_a(0, 5), pk_d(0, 32'hA5A5_0001));
    step(4'b0001, 4'b0000, pk_a(0, 5), '0);

    // response routing: req1 and req3 back-to-back reads
    step(4'b0010, 4'b0010, pk_a(1, 2), pk_d(1, 32'h1111_2222));
    step(4'b1000, 4'b1000, pk_a(3, 7), pk_d(3, 32'h3333_7777));
    step(4'b0010, 4'b0000, pk_a(1, 2), '0);
    step(4'b1000, 4'b0000, pk_a(3, 7), '0);
    step('0, '0, '0, '0);

    // randomized traffic over a small address window to exercise hazards
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < N; s++) begin
        a[s*AW +: AW] = AW'($urandom_range(0, 15));
        d[s*32 +: 32] = $urandom;
      end
      step(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), a, d);
    end
    step('0, '0, '0, '0);

    // reset right after a read is accepted: the read must never respond
    step(4'b0001, 4'b0001, pk_a(0, 5), pk_d(0, 32'hDEAD_BEEF));
    step(4'b0100, 4'b0000, pk_a(2, 5), '0);
    @(posedge clk); #1;
    assert_reset();
    release_seq();
    step(4'b0001, 4'b0000, pk_a(0, 5), '0);
    for (int n = 0; n < 3; n++) step('0, '0, '0, '0);
    check("drain", exp_q.size(), 0);

`ifdef RAM_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", grant_cnt[i*CNT_W +: CNT_W], CNT_W'(gcnt[i]));
    check("conflict_cnt", conflict_cnt, CNT_W'(ccnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
